// File: rtl/man_mult_arbiter.sv
// Round-robin arbiter sharing one multi-cycle mantissa multiplier between two requesters.
// Latency: accept to resp_valid_o is 2 + BlankCycles cycles minimum, at most 1 + TimeoutCycles.
// Backpressure: one operation in flight; req_ready_o stays low until the response is accepted.
module man_mult_arbiter #(
    parameter int Width         = 28,
    parameter int BlankCycles   = 2,
    parameter int TimeoutCycles = 24
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [2*Width-1:0] req_a_i,
    input  logic [2*Width-1:0] req_b_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic               resp_id_o,
    output logic [Width-1:0]   resp_low_o,
    output logic [Width-1:0]   resp_high_o,
    output logic               resp_timeout_o,
    output logic               mult_start_o,
    output logic [Width-1:0]   mult_a_o,
    output logic [Width-1:0]   mult_b_o,
    input  logic               mult_done_i,
    input  logic [Width-1:0]   mult_low_i,
    input  logic [Width-1:0]   mult_high_i
);

    localparam int              CntW        = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] BlankCnt    = CntW'(BlankCycles);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] CntMax      = '1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic             id;
        logic             timeout;
        logic [Width-1:0] high;
        logic [Width-1:0] low;
    } resp_t;

    state_t          state;
    logic            prio;
    logic [CntW-1:0] cnt;
    logic            op_id;
    resp_t           resp_q;

    logic             grant_vld;
    logic             grant_id;
    logic [Width-1:0] grant_a;
    logic [Width-1:0] grant_b;

    assign resp_id_o      = resp_q.id;
    assign resp_timeout_o = resp_q.timeout;
    assign resp_high_o    = resp_q.high;
    assign resp_low_o     = resp_q.low;

    // Ready is gated by reset so no requester sees a handshake the FSM cannot take.
    always_comb begin
        grant_id    = req_valid_i[prio] ? prio : ~prio;
        grant_vld   = (state == IDLE) && reset_i && (req_valid_i != 2'b00);
        grant_a     = grant_id ? req_a_i[2*Width-1:Width] : req_a_i[Width-1:0];
        grant_b     = grant_id ? req_b_i[2*Width-1:Width] : req_b_i[Width-1:0];
        req_ready_o = 2'b00;
        if (grant_vld) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state        <= IDLE;
            prio         <= 1'b0;
            cnt          <= '0;
            op_id        <= 1'b0;
            mult_a_o     <= '0;
            mult_b_o     <= '0;
            mult_start_o <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_id        <= grant_id;
                        mult_a_o     <= grant_a;
                        mult_b_o     <= grant_b;
                        mult_start_o <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    mult_start_o <= 1'b0;
                    cnt          <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (cnt != CntMax) begin
                        cnt <= cnt + 1'b1;
                    end
                    // Done from the previous operation is sticky, so it is ignored while blanking.
                    if (cnt >= BlankCnt && mult_done_i) begin
                        resp_q.id      <= op_id;
                        resp_q.timeout <= 1'b0;
                        resp_q.high    <= mult_high_i;
                        resp_q.low     <= mult_low_i;
                        resp_valid_o   <= 1'b1;
                        state          <= RESP;
                    end else if (cnt >= TimeoutLast) begin
                        resp_q.id      <= op_id;
                        resp_q.timeout <= 1'b1;
                        resp_q.high    <= '0;
                        resp_q.low     <= '0;
                        resp_valid_o   <= 1'b1;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        prio         <= ~resp_q.id;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_man_mult_arbiter.sv
// Bench for man_mult_arbiter: directed vector table, reset sequence and random traffic
// checked against a transaction-level model of arbitration, latency and product.
module tb_man_mult_arbiter;

    localparam int W     = 28;
    localparam int BLANK = 2;
    localparam int TMO   = 24;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [1:0]     req_valid_i;
    logic [1:0]     req_ready_o;
    logic [2*W-1:0] req_a_i;
    logic [2*W-1:0] req_b_i;
    logic           resp_valid_o;
    logic           resp_ready_i;
    logic           resp_id_o;
    logic [W-1:0]   resp_low_o;
    logic [W-1:0]   resp_high_o;
    logic           resp_timeout_o;
    logic           mult_start_o;
    logic [W-1:0]   mult_a_o;
    logic [W-1:0]   mult_b_o;
    logic           mult_done_i;
    logic [W-1:0]   mult_low_i;
    logic [W-1:0]   mult_high_i;

    int n_checks = 0;
    int n_fail   = 0;

    man_mult_arbiter #(
        .Width(W),
        .BlankCycles(BLANK),
        .TimeoutCycles(TMO)
    ) dut (
        .clk(clk),
        .reset_i(reset_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_a_i(req_a_i),
        .req_b_i(req_b_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .resp_id_o(resp_id_o),
        .resp_low_o(resp_low_o),
        .resp_high_o(resp_high_o),
        .resp_timeout_o(resp_timeout_o),
        .mult_start_o(mult_start_o),
        .mult_a_o(mult_a_o),
        .mult_b_o(mult_b_o),
        .mult_done_i(mult_done_i),
        .mult_low_i(mult_low_i),
        .mult_high_i(mult_high_i)
    );

    always #5 clk = ~clk;

    // Multiplier model: product taken at the start pulse, done rises mdly cycles later and stays high.
    int             mdly = 0;
    int             dcnt = 0;
    logic [2*W-1:0] prod = '0;

    always @(posedge clk) begin
        if (mult_start_o) begin
            prod <= (2*W)'(mult_a_o) * (2*W)'(mult_b_o);
            dcnt <= mdly;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end
    end

    assign mult_done_i = (dcnt == 0);
    assign mult_low_i  = prod[W-1:0];
    assign mult_high_i = prod[2*W-1:W];

    // Reference model state: the requester preferred at the next grant.
    logic ptr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic [1:0] vld, input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1, input int dly,
                           input int stall, input logic [1:0] pend, input logic exp_id,
                           input logic [2*W-1:0] exp_prod, input logic exp_to, input int exp_lat);
        int             n;
        int             e;
        int             starts;
        logic           bad_rdy;
        logic           unstable;
        logic [1:0]     gmask;
        logic [2*W+1:0] snap;
        gmask        = 2'b01 << exp_id;
        mdly         = dly;
        resp_ready_i = 1'b0;
        @(negedge clk);
        req_valid_i = vld;
        req_a_i     = {a1, a0};
        req_b_i     = {b1, b0};
        #1;
        n = 0;
        while (req_ready_o == 2'b00 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("grant_wait", 64'(n), 64'(0));
        check("req_ready", 64'(req_ready_o), 64'(gmask));
        @(posedge clk);
        #1;
        req_valid_i = (vld & ~gmask) | pend;
        starts  = mult_start_o ? 1 : 0;
        bad_rdy = (req_ready_o != 2'b00);
        e = 0;
        do begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (req_ready_o != 2'b00) bad_rdy = 1'b1;
            if (mult_start_o) starts++;
        end while (!resp_valid_o && e < 100);
        check("latency", 64'(e), 64'(exp_lat));
        check("start_pulses", 64'(starts), 64'(1));
        check("resp_id", 64'(resp_id_o), 64'(exp_id));
        check("resp_low", 64'(resp_low_o), 64'(exp_prod[W-1:0]));
        check("resp_high", 64'(resp_high_o), 64'(exp_prod[2*W-1:W]));
        check("resp_timeout", 64'(resp_timeout_o), 64'(exp_to));
        snap     = {resp_id_o, resp_timeout_o, resp_high_o, resp_low_o};
        unstable = 1'b0;
        repeat (stall) begin
            @(negedge clk);
            if ({resp_id_o, resp_timeout_o, resp_high_o, resp_low_o} !== snap || !resp_valid_o)
                unstable = 1'b1;
            if (req_ready_o != 2'b00) bad_rdy = 1'b1;
        end
        check("resp_stable", 64'(unstable), 64'(0));
        check("ready_outside_idle", 64'(bad_rdy), 64'(0));
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_i = 1'b0;
        ptr = ~exp_id;
    endtask

    typedef struct {
        logic [1:0]     vld;
        logic [W-1:0]   a0, b0, a1, b1;
        int             dly;
        int             stall;
        logic [1:0]     pend;
        logic           exp_id;
        logic [2*W-1:0] exp_prod;
        logic           exp_to;
        int             exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic           stale;
        logic [1:0]     vld;
        logic [W-1:0]   a0, b0, a1, b1;
        int             dly;
        int             stall;
        logic           id;
        logic           to;
        logic [2*W-1:0] p;
        int             k;

        vecs[0] = '{2'b01, 28'd3, 28'd5, 28'd0, 28'd0, 6, 0, 2'b00, 1'b0, 56'd15, 1'b0, 8};
        vecs[1] = '{2'b10, 28'd0, 28'd0, 28'd1000, 28'd1000, 1000, 2, 2'b00, 1'b1, 56'd0, 1'b1, 25};
        vecs[2] = '{2'b11, 28'hFFFFFFF, 28'hFFFFFFF, 28'd1000, 28'd1000, 0, 0, 2'b00, 1'b0,
                    56'hFFFFFFE0000001, 1'b0, 4};
        vecs[3] = '{2'b11, 28'hFFFFFFF, 28'hFFFFFFF, 28'd1000, 28'd1000, 23, 0, 2'b00, 1'b1,
                    56'd1000000, 1'b0, 25};
        vecs[4] = '{2'b11, 28'hFFFFFFF, 28'hFFFFFFF, 28'd1000, 28'd1000, 24, 0, 2'b00, 1'b0,
                    56'd0, 1'b1, 25};
        vecs[5] = '{2'b01, 28'd3, 28'd5, 28'd1000, 28'd1000, 3, 10, 2'b10, 1'b0, 56'd15, 1'b0, 5};
        vecs[6] = '{2'b10, 28'd3, 28'd5, 28'd1000, 28'd1000, 2, 0, 2'b00, 1'b1, 56'd1000000, 1'b0, 4};
        vecs[7] = '{2'b01, 28'd2, 28'd9, 28'd0, 28'd0, 1, 0, 2'b00, 1'b0, 56'd18, 1'b0, 4};

        reset_i      = 1'b0;
        req_valid_i  = 2'b00;
        req_a_i      = '0;
        req_b_i      = '0;
        resp_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({req_ready_o, resp_valid_o, resp_id_o, resp_timeout_o, mult_start_o}), 64'(0));
        check("reset_resp", 64'({resp_high_o, resp_low_o}), 64'(0));
        check("reset_ops", 64'({mult_a_o, mult_b_o}), 64'(0));
        reset_i = 1'b1;
        ptr     = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].vld, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1, vecs[i].dly,
                    vecs[i].stall, vecs[i].pend, vecs[i].exp_id, vecs[i].exp_prod,
                    vecs[i].exp_to, vecs[i].exp_lat);
        end

        // Reset pulled low between edges while the multiplier is still busy.
        mdly = 1000;
        @(negedge clk);
        req_valid_i = 2'b01;
        req_a_i     = {28'd0, 28'd11};
        req_b_i     = {28'd0, 28'd13};
        #1;
        check("rst_txn_ready", 64'(req_ready_o), 64'(2'b01));
        @(posedge clk);
        #1;
        req_valid_i = 2'b00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        reset_i = 1'b0;
        #1;
        check("async_rst_ctrl", 64'({req_ready_o, resp_valid_o, resp_id_o, resp_timeout_o, mult_start_o}), 64'(0));
        check("async_rst_resp", 64'({resp_high_o, resp_low_o}), 64'(0));
        check("async_rst_ops", 64'({mult_a_o, mult_b_o}), 64'(0));
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b1;
        ptr     = 1'b0;
        stale   = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (resp_valid_o || mult_start_o) stale = 1'b1;
        end
        check("no_stale_resp", 64'(stale), 64'(0));
        run_txn(2'b11, 28'd5, 28'd7, 28'd1000, 28'd1000, 0, 0, 2'b00, 1'b0, 56'd35, 1'b0, 4);

        // Random traffic against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            vld   = 2'($urandom_range(1, 3));
            a0    = W'($urandom());
            b0    = W'($urandom());
            a1    = W'($urandom());
            b1    = W'($urandom());
            dly   = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 26));
            stall = int'($urandom_range(0, 3));
            id    = vld[ptr] ? ptr : ~ptr;
            to    = (dly >= TMO);
            p     = id ? (2*W)'(a1) * (2*W)'(b1) : (2*W)'(a0) * (2*W)'(b0);
            if (to) p = '0;
            k     = to ? TMO - 1 : ((dly > BLANK) ? dly : BLANK);
            run_txn(vld, a0, b0, a1, b1, dly, stall, 2'b00, id, p, to, k + 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/man_mult_arbiter.md
Name: man_mult_arbiter

Overview:
- Shares one multi-cycle mantissa multiplier (Width-bit operands, 2*Width-bit product split into low/high halves) between two requesters, e.g. two FP multiply lanes.
- Arbitrates round-robin, latches the winner's operands, and sequences the multiplier: one-cycle start pulse, done blanking, optional timeout.
- Returns the product with the requester ID over a valid/ready response channel.
- Sits between the FP multiply front-ends and the mantissa multiplier instance.

Parameters:
Width, 28, operand width and width of each product half
BlankCycles, 2, WAIT cycles during which mult_done_i is ignored (multiplier done is sticky from the previous operation)
TimeoutCycles, 24, WAIT cycles after which the operation is abandoned

Ports:
clk  input  1  clock; all flops rising-edge
reset_i  input  1  asynchronous, active-low reset
req_valid_i  input  2  per-requester request valid
req_ready_o  output  2  per-requester accept; at most one bit high
req_a_i  input  2*Width  multiplier operands; requester k on bits [k*Width +: Width]
req_b_i  input  2*Width  multiplicand operands; same packing as req_a_i
resp_valid_o  output  1  response valid
resp_ready_i  input  1  response accept
resp_id_o  output  1  index of the requester that owns the response
resp_low_o  output  Width  product bits [Width-1:0]
resp_high_o  output  Width  product bits [2*Width-1:Width]
resp_timeout_o  output  1  response was produced by timeout; product fields are 0
mult_start_o  output  1  start pulse to the multiplier
mult_a_o  output  Width  multiplier operand, held stable from START through RESP
mult_b_o  output  Width  multiplicand operand, held stable from START through RESP
mult_done_i  input  1  multiplier done
mult_low_i  input  Width  multiplier product low half
mult_high_i  input  Width  multiplier product high half

Behaviour:
- Reset (reset_i low, asynchronous): state=IDLE, priority pointer=0 (requester 0 preferred), counter=0, all outputs 0. Operand and response registers clear to 0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req_valid_i bit is high, grant the preferred requester if it is valid, otherwise the other one.
  - req_ready_o[grant] is high combinationally in the same cycle; the handshake completes that cycle.
  - Latch a, b and id into the operand registers, then go to START.
  - req_ready_o is 0 in every state other than IDLE.
- START:
  - mult_start_o=1 for exactly this one cycle.
  - Clear the counter, then go to WAIT.
- WAIT:
  - The counter increments every cycle and saturates.
  - Complete when counter >= BlankCycles and mult_done_i=1: capture {mult_high_i, mult_low_i} into the response registers, timeout flag=0, go to RESP.
  - Otherwise, when counter reaches TimeoutCycles-1: response product=0, timeout flag=1, go to RESP.
  - If both conditions hold in the same cycle, the done path wins.
- RESP:
  - resp_valid_o=1; resp_id_o, resp_low_o, resp_high_o and resp_timeout_o stay stable until the handshake.
  - On resp_valid_o && resp_ready_i: the priority pointer becomes the non-granted requester, then go to IDLE.
  - A new grant is therefore possible at the earliest the cycle after the response handshake.
- Minimum latency: request accept to resp_valid_o is 1 (START) + BlankCycles + 1 cycles, i.e. 4 cycles with the defaults when mult_done_i is already high.
- Requesters must hold valid and operands until they see ready. Dropping valid before the grant is legal; the request is then not served.
- Response stall: resp_ready_i held low keeps the FSM in RESP indefinitely; no new grants occur.
- Reset mid-operation returns the block to IDLE immediately and discards the in-flight result. The multiplier is expected to share the same reset.

Test Plan:
- Single request: req_valid_i=01, a=3, b=5, mult model done 6 cycles after start with low=15, high=0 -> req_ready_o=01 for one cycle, mult_start_o one-cycle pulse, resp_valid_o with id=0, low=15, high=0, timeout=0.
- Contention: req_valid_i=11 held for three transactions -> grant order 0,1,0 (resp_id_o sequence 0,1,0); req_ready_o never 11.
- Sticky done: mult_done_i tied high -> response captured exactly BlankCycles cycles into WAIT, 4 cycles after accept.
- Timeout: mult_done_i tied low -> resp_valid_o after TimeoutCycles WAIT cycles with resp_timeout_o=1, low=0, high=0.
- Backpressure: resp_ready_i low for 10 cycles with req_valid_i=10 pending -> response fields stable; req_ready_o=00 throughout; requester 1 granted the cycle after the response handshake.
- Async reset mid-WAIT: reset_i pulled low between clock edges -> all outputs 0 immediately, no stale response after release; next request is served with requester 0 preferred.
